// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for DIV/DIVU.
// One quotient bit per clock; HI = remainder, LO = quotient.
// The start/busy/done handshake lets control stall the pipeline while a divide runs.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic             negq_q, negq_d;   // negate quotient at the end
  logic             negr_q, negr_d;   // negate remainder at the end
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             dbz_q, dbz_d;

  // Operand magnitudes; MIN maps to 2^(WIDTH-1) as an unsigned value, which is exact.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  always_comb begin
    a_neg = signed_op & dividend[WIDTH-1];
    b_neg = signed_op & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
  end

  // One restoring step. Since rem < divisor, the shifted value is below 2*divisor,
  // so a WIDTH+1-bit trial is enough and its MSB is the borrow.
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
    q_fin = negq_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fin = negr_q ? (~rem_nx + 1'b1) : rem_nx;
  end

  // Next-state and datapath control; results are written on the edge into FIN
  // so they are already valid in the done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          dvs_d  = b_mag;
          quo_d  = a_mag;
          rem_d  = '0;
          if (divisor == '0) begin
            // Divide by zero skips the iterations entirely.
            qout_d  = '1;
            rout_d  = dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          qout_d  = q_fin;
          rout_d  = r_fin;
          dbz_d   = 1'b0;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any divide in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake decoded straight from the state register.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    quotient    = qout_q;
    remainder   = rout_q;
    div_by_zero = dbz_q;
  end

endmodule
